en_reg_pipe: RTL and testbench

Parametrised, enable-gated register pipeline: WIDTH-bit data moves through DEPTH clocked stages, each stage carrying a valid bit, with flush and an occupancy counter. It is the clocked, multi-stage successor to the team's single-bit enabled storage element. It sits between a producer and a consumer that need a fixed, stallable delay line. All state changes occur only on clock edges; there is no transparent path from d to q.

---
 rtl/en_reg_pipe_pkg.sv | 6 +
 rtl/en_reg_stage.sv | 25 ++
 rtl/en_reg_pipe.sv | 52 +++++
 tb/tb_en_reg_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/en_reg_pipe_pkg.sv
// en_reg_pipe_pkg: sizing helper shared by en_reg_pipe and its parents
package en_reg_pipe_pkg;
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/en_reg_stage.sv
// en_reg_stage: one enable-gated data register with its valid tag
module en_reg_stage #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr_valid,
   input  logic [WIDTH-1:0] d,
   input  logic             v_in,
   output logic [WIDTH-1:0] q,
   output logic             v
);
   always_ff @(posedge clk)
      if (!reset) begin
         q <= RESET_VAL;
         v <= 1'b0;
      end else if (clr_valid)
         v <= 1'b0;
      else if (en) begin
         q <= d;
         v <= v_in;
      end
endmodule

// File: rtl/en_reg_pipe.sv
// en_reg_pipe: stallable DEPTH-stage register pipeline with valid tags, flush and occupancy count
module en_reg_pipe
   import en_reg_pipe_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      flush,
   input  logic [WIDTH-1:0]          d,
   input  logic                      d_valid,
   output logic [WIDTH-1:0]          q,
   output logic                      q_valid,
   output logic [cnt_w(DEPTH)-1:0]   count
);
   localparam int CW = cnt_w(DEPTH);
   if (DEPTH < 1) begin : g_depth_chk
      $error("en_reg_pipe: DEPTH must be >= 1");
   end
   logic [DEPTH-1:0][WIDTH-1:0] data;
   logic [DEPTH-1:0]            valid;
   logic [DEPTH:0][WIDTH-1:0]   data_in;
   logic [DEPTH:0]              valid_in;
   // Entry i of the *_in chains feeds stage i; the top entry is unused.
   assign data_in  = {data, d};
   assign valid_in = {valid, d_valid};
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      en_reg_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk       (clk),
         .reset     (reset),
         .en        (en),
         .clr_valid (flush),
         .d         (data_in[i]),
         .v_in      (valid_in[i]),
         .q         (data[i]),
         .v         (valid[i])
      );
   end
   always_ff @(posedge clk)
      if (!reset || flush)
         count <= '0;
      else if (en)
         count <= count + CW'(d_valid) - CW'(valid[DEPTH-1]);
   assign q       = data[DEPTH-1];
   assign q_valid = valid[DEPTH-1];
endmodule

// File: tb/tb_en_reg_pipe.sv
// tb_en_reg_pipe: scoreboard bench for en_reg_pipe at DEPTH=4 and DEPTH=1
module tb_en_reg_pipe;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] d = 8'h00;
   logic       d_valid = 1'b0;
   logic [7:0] q, q1;
   logic       q_valid, q1_valid;
   logic [2:0] count;
   logic [0:0] count1;
   logic [7:0] sb[$];
   logic [7:0] exp_q;
   int         checks = 0;
   int         failures = 0;

   en_reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
      .q(q), .q_valid(q_valid), .count(count)
   );
   en_reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) dut1 (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
      .q(q1), .q_valid(q1_valid), .count(count1)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0; en = 1'b1; d = 8'h77; d_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks += 5;
         if (q !== 8'hA5) begin failures++; $display("FAIL reset_q edge%0d: got %h want a5", k, q); end
         if (q_valid !== 1'b0) begin failures++; $display("FAIL reset_qv edge%0d: got %b want 0", k, q_valid); end
         if (count !== 3'd0) begin failures++; $display("FAIL reset_count edge%0d: got %0d want 0", k, count); end
         if (q1 !== 8'hA5) begin failures++; $display("FAIL reset_q1 edge%0d: got %h want a5", k, q1); end
         if (count1 !== 1'b0) begin failures++; $display("FAIL reset_count1 edge%0d: got %0d want 0", k, count1); end
      end
      reset = 1'b1; en = 1'b0; d_valid = 1'b0;
   endtask

   task automatic test_streaming;
      int ec, ein, eout;
      logic ev;
      for (int k = 0; k < 10; k++) begin
         en = 1'b1;
         d_valid = (k < 6);
         d = (k < 6) ? 8'(k + 1) : 8'h00;
         if (d_valid) sb.push_back(d);
         tick();
         ein = (k + 1 < 6) ? k + 1 : 6;
         eout = (k - 3 < 0) ? 0 : ((k - 3 > 6) ? 6 : k - 3);
         ec = ein - eout;
         ev = (k >= 3 && k <= 8);
         checks += 2;
         if (count !== 3'(ec)) begin failures++; $display("FAIL stream_count edge%0d: got %0d want %0d", k, count, ec); end
         if (q_valid !== ev) begin failures++; $display("FAIL stream_qv edge%0d: got %b want %b", k, q_valid, ev); end
         if (q_valid === 1'b1) begin
            checks++;
            exp_q = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            if (q !== exp_q) begin failures++; $display("FAIL stream_q edge%0d: got %h want %h", k, q, exp_q); end
         end
      end
   endtask

   task automatic test_stall;
      logic [2:0] ec[4] = '{3'd3, 3'd2, 3'd1, 3'd0};
      logic       ev[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      en = 1'b1; d = 8'h00; d_valid = 1'b0;
      repeat (4) tick();
      for (int k = 0; k < 3; k++) begin
         d = 8'(8'h11 + k); d_valid = 1'b1;
         sb.push_back(d);
         tick();
      end
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         d = k[0] ? 8'hF0 : 8'h0F; d_valid = 1'b1;
         tick();
         checks += 3;
         if (q !== 8'h00) begin failures++; $display("FAIL stall_q cyc%0d: got %h want 00", k, q); end
         if (q_valid !== 1'b0) begin failures++; $display("FAIL stall_qv cyc%0d: got %b want 0", k, q_valid); end
         if (count !== 3'd3) begin failures++; $display("FAIL stall_count cyc%0d: got %0d want 3", k, count); end
      end
      en = 1'b1; d = 8'h00; d_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks += 2;
         if (count !== ec[k]) begin failures++; $display("FAIL drain_count edge%0d: got %0d want %0d", k, count, ec[k]); end
         if (q_valid !== ev[k]) begin failures++; $display("FAIL drain_qv edge%0d: got %b want %b", k, q_valid, ev[k]); end
         if (q_valid === 1'b1) begin
            checks++;
            exp_q = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            if (q !== exp_q) begin failures++; $display("FAIL drain_q edge%0d: got %h want %h", k, q, exp_q); end
         end
      end
   endtask

   task automatic test_bubbles;
      logic [3:0] pat = 4'b1101;
      int ec;
      logic ev;
      for (int k = 0; k < 8; k++) begin
         en = 1'b1;
         d = (k < 4) ? 8'(8'h21 + k) : 8'h00;
         d_valid = (k < 4) ? pat[k] : 1'b0;
         if (d_valid) sb.push_back(d);
         tick();
         ec = 0;
         for (int j = 0; j < 4; j++) begin
            if (pat[j] && j <= k) ec++;
            if (pat[j] && j + 4 <= k) ec--;
         end
         ev = (k >= 3 && k <= 6) ? pat[k-3] : 1'b0;
         checks += 3;
         if (q_valid !== ev) begin failures++; $display("FAIL bubble_qv edge%0d: got %b want %b", k, q_valid, ev); end
         if (count !== 3'(ec)) begin failures++; $display("FAIL bubble_count edge%0d: got %0d want %0d", k, count, ec); end
         if (count > 3'd3) begin failures++; $display("FAIL bubble_count_max edge%0d: got %0d want <=3", k, count); end
         if (k == 4) begin
            checks++;
            if (q !== 8'h22) begin failures++; $display("FAIL bubble_data edge%0d: got %h want 22", k, q); end
         end
         if (q_valid === 1'b1) begin
            checks++;
            exp_q = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            if (q !== exp_q) begin failures++; $display("FAIL bubble_q edge%0d: got %h want %h", k, q, exp_q); end
         end
      end
   endtask

   task automatic test_flush;
      en = 1'b1; d_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         d = 8'(8'h31 + k);
         sb.push_back(d);
         tick();
      end
      checks += 3;
      if (count !== 3'd4) begin failures++; $display("FAIL flush_pre_count: got %0d want 4", count); end
      if (q_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_qv: got %b want 1", q_valid); end
      if (q !== 8'h31) begin failures++; $display("FAIL flush_pre_q: got %h want 31", q); end
      flush = 1'b1; en = 1'b1; d = 8'hFF; d_valid = 1'b1;
      tick();
      sb.delete();
      checks += 3;
      if (count !== 3'd0) begin failures++; $display("FAIL flush_count: got %0d want 0", count); end
      if (q_valid !== 1'b0) begin failures++; $display("FAIL flush_qv: got %b want 0", q_valid); end
      if (q !== 8'h31) begin failures++; $display("FAIL flush_q_hold: got %h want 31", q); end
      flush = 1'b0; d = 8'h00; d_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks += 2;
         if (q_valid !== 1'b0 || q === 8'hFF) begin failures++; $display("FAIL flush_ff_leak edge%0d: got %h/%b want not valid", k, q, q_valid); end
         if (count !== 3'd0) begin failures++; $display("FAIL flush_post_count edge%0d: got %0d want 0", k, count); end
      end
   endtask

   task automatic test_reset_mid;
      en = 1'b1; d_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         d = 8'(8'h41 + k);
         tick();
      end
      checks++;
      if (count !== 3'd2) begin failures++; $display("FAIL rmid_pre_count: got %0d want 2", count); end
      reset = 1'b0; d = 8'h43;
      tick();
      checks += 3;
      if (count !== 3'd0) begin failures++; $display("FAIL rmid_count: got %0d want 0", count); end
      if (q_valid !== 1'b0) begin failures++; $display("FAIL rmid_qv: got %b want 0", q_valid); end
      if (q !== 8'hA5) begin failures++; $display("FAIL rmid_q: got %h want a5", q); end
      reset = 1'b1; en = 1'b1; d = 8'h51; d_valid = 1'b1;
      sb.push_back(d);
      tick();
      checks++;
      if (count !== 3'd1) begin failures++; $display("FAIL release_count: got %0d want 1", count); end
      d = 8'h00; d_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (q_valid !== (k == 2)) begin failures++; $display("FAIL release_qv edge%0d: got %b want %b", k, q_valid, k == 2); end
         if (q_valid === 1'b1) begin
            checks++;
            exp_q = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            if (q !== exp_q) begin failures++; $display("FAIL release_q edge%0d: got %h want %h", k, q, exp_q); end
         end
      end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
   endtask

   task automatic test_depth1;
      en = 1'b1; d = 8'h3C; d_valid = 1'b1;
      tick();
      checks += 3;
      if (q1 !== 8'h3C) begin failures++; $display("FAIL d1_q: got %h want 3c", q1); end
      if (q1_valid !== 1'b1) begin failures++; $display("FAIL d1_qv: got %b want 1", q1_valid); end
      if (count1 !== 1'b1) begin failures++; $display("FAIL d1_count: got %0d want 1", count1); end
      en = 1'b0; d = 8'h77;
      tick();
      checks += 2;
      if (q1 !== 8'h3C) begin failures++; $display("FAIL d1_hold_q: got %h want 3c", q1); end
      if (count1 !== 1'b1) begin failures++; $display("FAIL d1_hold_count: got %0d want 1", count1); end
      en = 1'b1; d = 8'h00; d_valid = 1'b0;
      tick();
      checks += 3;
      if (q1 !== 8'h00) begin failures++; $display("FAIL d1_exit_q: got %h want 00", q1); end
      if (q1_valid !== 1'b0) begin failures++; $display("FAIL d1_exit_qv: got %b want 0", q1_valid); end
      if (count1 !== 1'b0) begin failures++; $display("FAIL d1_exit_count: got %0d want 0", count1); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_stall();
      test_bubbles();
      test_flush();
      test_reset_mid();
      test_depth1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
